if_prefetch_stage: RTL and testbench
====================================

Name: if_prefetch_stage

Overview:
Instruction-fetch stage with a small prefetch queue. It sits between the PC/instruction memory and the IF/ID pipeline register.
- Issues sequential word fetches to the synchronous instruction memory and buffers the returned instructions with their PCs.
- Presents one instruction per cycle to decode.
- Honours the decode-stage hazard stall and branch/jump redirects, which flush the queue.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16
RESET_PC, 32'h00003000, first fetch address after reset
IADDR_W, 10, instruction-memory word-index width (imem_addr = pc[IADDR_W+1:2])

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
hazard  in  1  decode stall; head entry is held, not popped
redirect  in  1  branch taken or jump resolved in ID
redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
imem_req  out  1  read request to instruction memory this cycle
imem_addr  out  IADDR_W  word index of requested instruction
imem_rdata  in  32  instruction; valid the cycle after imem_req
id_valid  out  1  head entry present
id_pc  out  32  address+4 of head instruction (decode computes branch targets from this)
id_instr  out  32  head instruction; 32'h0 (nop) when id_valid=0
fifo_level  out  $clog2(DEPTH)+1  queued entry count, 0..DEPTH

Behaviour:
- State:
  - fetch_pc (32b)
  - inflight flag plus inflight_pc
  - circular queue: rd_ptr, wr_ptr, level
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC; inflight=0; level=0; pointers=0.
  - Outputs while reset asserted: imem_req=0, id_valid=0, id_instr=0, id_pc=0, fifo_level=0.
- Request rule:
  - imem_req=1 when !rst && !redirect && (level + inflight) < DEPTH.
  - On request, at the edge: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4. If no new request, inflight<=0.
  - Addition is modulo 2^32 and wraps silently.
- Response: when inflight=1 (and no redirect this cycle), imem_rdata is written at wr_ptr with pc=inflight_pc+4 at the edge.
- Pop: when id_valid && !hazard && !redirect, rd_ptr advances at the edge.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap mod DEPTH.
- Head is combinational from queue[rd_ptr]; id_valid = (level != 0).
- Latency: first request in the first cycle with rst=0; id_valid rises 2 cycles later. Steady state is one instruction per cycle.
- Full: level + inflight == DEPTH → imem_req=0; fetch_pc holds.
- Empty: id_valid=0, id_instr=0. A pop request with level 0 is ignored.
- Redirect has top priority over push, pop and hazard. At the edge:
  - level=0, rd_ptr=wr_ptr=0.
  - Any inflight response is discarded (inflight<=0).
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - imem_req=0 in the redirect cycle; the first target request is in the next cycle, so the target instruction is visible 2 cycles after that.
- Redirect while hazard=1: flush still occurs; the stalled decode instruction is the owner of the redirect.
- Reset mid-operation: all queued and inflight data discarded; restart at RESET_PC.
- No combinational path from imem_rdata to any output.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_flush_cnt[31:0], both 0 on reset and wrapping at 2^32.
  - perf_fetch_cnt increments by 1 per pop.
  - perf_flush_cnt adds level+inflight on each redirect.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Imem word i = 32'h1000_0000+i; release rst, hazard=0 → id_valid rises cycle 2 with id_pc=32'h00003004, id_instr=32'h1000_0000; then one new instruction per cycle, id_pc increasing by 4.
- Hold hazard=1 for 10 cycles after first valid → fifo_level saturates at 4; imem_req=0 once level+inflight=4; id_instr stays 32'h1000_0000. Release hazard → 4 consecutive pops with id_pc 3004, 3008, 300C, 3010; no gap or duplicate.
- Redirect with redirect_pc=32'h0000_3043 while level=3 and inflight=1 → next cycle fifo_level=0, id_valid=0; request at imem_addr=10'h010; first output id_pc=32'h00003044. With IF_PERF_CNT_EN, perf_flush_cnt=4.
- Redirect and hazard both asserted with response inflight → inflight data not pushed; fifo_level=0 next cycle.
- Assert rst for 1 cycle while level=2 → all outputs 0; fetch restarts at imem_addr=10'h000 (RESET_PC word).
- Set fetch wrap via redirect_pc=32'hFFFF_FFFC → outputs id_pc=32'h0000_0000, then 32'h0000_0004.

Source files
------------

// File: rtl/if_prefetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage_if
//   Bundles the fetch stage's instruction-memory bus and its decode-side
//   handshake so the stage and its environment connect through one port.
//
//   Signals
//     hazard       decode stall; the head entry is held
//     redirect     branch/jump resolved in decode; flushes the stage
//     redirect_pc  new fetch address (bits [1:0] ignored)
//     imem_req     read request to instruction memory
//     imem_addr    word index of the requested instruction
//     imem_rdata   instruction, valid the cycle after imem_req
//     id_valid     head entry present
//     id_pc        address+4 of the head instruction
//     id_instr     head instruction, 0 when id_valid=0
//     fifo_level   number of queued entries, 0..DEPTH
//
//   Modports
//     master  the fetch stage
//     slave   the environment (PC/imem side and decode)
// -----------------------------------------------------------------------------
interface if_prefetch_stage_if #(
    parameter int IADDR_W = 10,
    parameter int DEPTH   = 4
);
    logic                       hazard;
    logic                       redirect;
    logic [31:0]                redirect_pc;
    logic                       imem_req;
    logic [IADDR_W-1:0]         imem_addr;
    logic [31:0]                imem_rdata;
    logic                       id_valid;
    logic [31:0]                id_pc;
    logic [31:0]                id_instr;
    logic [$clog2(DEPTH):0]     fifo_level;

    modport master (
        input  hazard, redirect, redirect_pc, imem_rdata,
        output imem_req, imem_addr, id_valid, id_pc, id_instr, fifo_level
    );

    modport slave (
        output hazard, redirect, redirect_pc, imem_rdata,
        input  imem_req, imem_addr, id_valid, id_pc, id_instr, fifo_level
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage
//   Instruction-fetch stage with a small prefetch queue between the
//   synchronous instruction memory and the IF/ID register. Issues sequential
//   word fetches, buffers returned instructions with their PC+4, presents the
//   head entry to decode, honours the decode stall and flushes on redirect.
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   if_prefetch_stage_if.master (imem bus + decode handshake)
//     perf_fetch_cnt / perf_flush_cnt   only with IF_PERF_CNT_EN defined:
//           pops performed, and entries (queued + inflight) discarded by
//           redirects; both wrap at 2^32.
//
//   Optional feature macro: IF_PERF_CNT_EN
// -----------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IADDR_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    if_prefetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Fetch state
    logic [31:0]        r_fetch_pc;
    logic               r_inflight;
    logic [31:0]        r_inflight_pc;

    // Circular queue; pointers wrap naturally because DEPTH is a power of two
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [31:0]        r_q_pc    [DEPTH];
    logic [31:0]        r_q_instr [DEPTH];

    logic [LVL_W:0]     w_occupancy;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_redirect_lsbs;

    // Queued plus inflight entries bounds new requests, so a response always
    // has a free slot and imem_rdata never needs back-pressure.
    assign w_occupancy = {1'b0, r_level} + (LVL_W+1)'(r_inflight);
    assign w_req       = !rst && !bus.redirect && (w_occupancy < (LVL_W+1)'(DEPTH));
    assign w_push      = r_inflight && !bus.redirect;
    assign w_pop       = (r_level != '0) && !bus.hazard && !bus.redirect;

    // Word-aligned target: the low address bits play no part in fetching.
    assign w_unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_level       <= '0;
        end else if (bus.redirect) begin
            // Flush wins over push, pop and hazard; inflight data is dropped.
            r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: queue storage is deliberately not reset; r_level alone says which
    // entries are meaningful, and skipping reset lets it map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_q_pc[r_wr_ptr]    <= r_inflight_pc + 32'd4;
            r_q_instr[r_wr_ptr] <= bus.imem_rdata;
        end
    end

    // Outputs come only from registers (and control inputs), never from
    // imem_rdata, so there is no combinational memory-to-decode path.
    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_fetch_pc[IADDR_W+1:2];
    assign bus.id_valid   = !rst && (r_level != '0);
    assign bus.id_pc      = bus.id_valid ? r_q_pc[r_rd_ptr]    : 32'h0;
    assign bus.id_instr   = bus.id_valid ? r_q_instr[r_rd_ptr] : 32'h0;
    assign bus.fifo_level = rst ? '0 : r_level;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_pop)        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.redirect) perf_flush_cnt <= perf_flush_cnt + 32'(w_occupancy);
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_stage
//   Self-checking bench for if_prefetch_stage (DEPTH=4, IADDR_W=10).
//   Instruction memory word i holds 32'h1000_0000+i. A reference model keeps a
//   queue of expected {pc+4, instr} entries: an entry is created when the
//   model predicts a request, becomes queued one cycle later, and is popped
//   and compared against the head when decode consumes it. Directed checks
//   pin the latency, saturation, redirect, reset and wrap scenarios.
// -----------------------------------------------------------------------------
module tb_if_prefetch_stage;

    localparam int          DEPTH    = 4;
    localparam int          IADDR_W  = 10;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk;
    logic rst;

    if_prefetch_stage_if #(.IADDR_W(IADDR_W), .DEPTH(DEPTH)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    if_prefetch_stage #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC),
        .IADDR_W (IADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.master)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        return 32'h1000_0000 + 32'(pc[IADDR_W+1:2]);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory: data the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
    end

    // ---------------- reference model / scoreboard ----------------
    entry_t      sb_q[$];
    bit          m_infl;
    entry_t      m_infl_ent;
    logic [31:0] m_fetch_pc;

    always @(negedge clk) begin
        bit     exp_req;
        entry_t head;
        if (rst) begin
            check("rst_req",   32'(bus.imem_req), 32'd0);
            check("rst_valid", 32'(bus.id_valid), 32'd0);
            check("rst_instr", bus.id_instr, 32'd0);
            check("rst_pc",    bus.id_pc, 32'd0);
            check("rst_level", 32'(bus.fifo_level), 32'd0);
            sb_q.delete();
            m_infl     = 1'b0;
            m_fetch_pc = RESET_PC;
        end else begin
            exp_req = !bus.redirect && ((sb_q.size() + int'(m_infl)) < DEPTH);
            check("m_req", 32'(bus.imem_req), 32'(exp_req));
            if (exp_req) check("m_addr", 32'(bus.imem_addr), 32'(m_fetch_pc[IADDR_W+1:2]));
            check("m_level", 32'(bus.fifo_level), 32'(sb_q.size()));
            check("m_valid", 32'(bus.id_valid), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) begin
                head = sb_q[0];
                check("m_pc",    bus.id_pc,    head.pc);
                check("m_instr", bus.id_instr, head.instr);
            end else begin
                check("m_nop", bus.id_instr, 32'd0);
            end
            // Advance the model to the state after the coming edge.
            if (bus.redirect) begin
                sb_q.delete();
                m_infl     = 1'b0;
                m_fetch_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (sb_q.size() != 0 && !bus.hazard) void'(sb_q.pop_front());
                if (m_infl) sb_q.push_back(m_infl_ent);
                m_infl = exp_req;
                if (exp_req) begin
                    m_infl_ent.pc    = m_fetch_pc + 32'd4;
                    m_infl_ent.instr = instr_at(m_fetch_pc);
                    m_fetch_pc       = m_fetch_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        bus.hazard      = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) tick();

        // Startup latency: request in cycle 0, head valid in cycle 2.
        tick(); rst = 1'b0;
        look(); check("c0_req", 32'(bus.imem_req), 32'd1);
                check("c0_addr", 32'(bus.imem_addr), 32'h000);
        tick(); look(); check("c1_valid", 32'(bus.id_valid), 32'd0);
        tick(); bus.hazard = 1'b1;
        look(); check("c2_valid", 32'(bus.id_valid), 32'd1);
                check("c2_pc", bus.id_pc, 32'h0000_3004);
                check("c2_instr", bus.id_instr, 32'h1000_0000);

        // Stall: queue saturates, requests stop, head is held.
        repeat (10) tick();
        look(); check("full_level", 32'(bus.fifo_level), 32'd4);
                check("full_req", 32'(bus.imem_req), 32'd0);
                check("full_instr", bus.id_instr, 32'h1000_0000);
        tick(); bus.hazard = 1'b0;
        for (int k = 0; k < 4; k++) begin
            look(); check("drain_pc", bus.id_pc, 32'h0000_3004 + 32'(4 * k));
            tick();
        end
        repeat (6) tick();

        // Build level=3 with one response inflight, then redirect.
        bus.hazard = 1'b1;
        repeat (8) tick();
        look(); check("fill_level", 32'(bus.fifo_level), 32'd4);
        tick(); bus.hazard = 1'b0;
        tick(); bus.hazard = 1'b1;
        tick(); bus.hazard = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_3043;
        look(); check("pre_redir_level", 32'(bus.fifo_level), 32'd3);
        tick(); bus.redirect = 1'b0;
        look(); check("redir_level", 32'(bus.fifo_level), 32'd0);
                check("redir_valid", 32'(bus.id_valid), 32'd0);
                check("redir_req", 32'(bus.imem_req), 32'd1);
                check("redir_addr", 32'(bus.imem_addr), 32'h010);
`ifdef IF_PERF_CNT_EN
                check("perf_flush", perf_flush_cnt, 32'd4);
`endif
        tick(); look(); check("redir_wait", 32'(bus.id_valid), 32'd0);
        tick(); look(); check("redir_tgt_pc", bus.id_pc, 32'h0000_3044);
                        check("redir_tgt_instr", bus.id_instr, 32'h1000_0010);

        // Redirect together with hazard while a response is inflight.
        repeat (3) tick();
        tick(); bus.hazard = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_3100;
        look(); check("rh_req", 32'(bus.imem_req), 32'd0);
        tick(); bus.redirect = 1'b0;
        look(); check("rh_level", 32'(bus.fifo_level), 32'd0);
                check("rh_valid", 32'(bus.id_valid), 32'd0);
        tick(); tick();
        look(); check("rh_level1", 32'(bus.fifo_level), 32'd1);

        // One-cycle reset with entries queued; restart from RESET_PC.
        tick(); rst = 1'b1;
        look(); check("mrst_level", 32'(bus.fifo_level), 32'd0);
                check("mrst_valid", 32'(bus.id_valid), 32'd0);
        tick(); rst = 1'b0; bus.hazard = 1'b0;
        look(); check("mrst_req", 32'(bus.imem_req), 32'd1);
                check("mrst_addr", 32'(bus.imem_addr), 32'h000);
        tick(); tick();
        look(); check("mrst_pc", bus.id_pc, 32'h0000_3004);

        // Fetch address wraps past 2^32.
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        tick(); bus.redirect = 1'b0;
        look(); check("wrap_addr", 32'(bus.imem_addr), 32'h3FF);
        tick(); tick();
        look(); check("wrap_pc0", bus.id_pc, 32'h0000_0000);
                check("wrap_instr0", bus.id_instr, 32'h1000_03FF);
        tick();
        look(); check("wrap_pc1", bus.id_pc, 32'h0000_0004);
                check("wrap_instr1", bus.id_instr, 32'h1000_0000);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #20000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
